vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Parametrised VRAM port arbiter and bus sequencer; the clocked, multi-channel successor to the gate-level VRAM interface. It accepts read/write requests from NCH requesters (default: PPU fetcher, CPU, OAM DMA) and arbitrates them by fixed priority. It drives one external SRAM-style VRAM bus with active-low address and strobes. While `lock` is high (PPU mode 3), masked channels get the DMG "blocked" behaviour: reads return all-ones, writes are dropped, and neither touches the bus.

## Interface
Parameters:
- AW, 13, address width.
- DW, 8, data width.
- NCH, 3, requester count; channel 0 has highest priority.
- STROBE, 1, cycles nMOE/nMWR held low; must be ≥1.
- LOCK_MASK, 3'b110, bit i set = channel i is blocked while `lock` is high.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- req  in  NCH  per-channel request; held until `ack`.
- we  in  NCH  per-channel write enable (1 = write); valid with `req`.
- addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
- wdata  in  NCH*DW  per-channel write data, same packing.
- lock  in  1  blocks channels in LOCK_MASK; sampled only at arbitration.
- ack  out  NCH  one-cycle pulse: request accepted.
- rvalid  out  NCH  one-cycle pulse: `rdata` valid for that channel.
- rdata  out  DW  read data shared by all channels.
- vram_na  out  AW  inverted VRAM address.
- vram_nmcs, vram_nmoe, vram_nmwr  out  1 each  active-low chip select, output enable, write strobe.
- vram_md_out  out  DW  write data.
- vram_md_oe  out  1  enables the data pad driver.
- vram_md_in  in  DW  read data from the pads.

## Operation
- States: IDLE, SETUP, ACTIVE, HOLD, BLOCK.
- Arbitration runs in IDLE and in the last HOLD cycle. The winner is the lowest-index channel with `req` high.
- Winner i is blocked (`lock` && LOCK_MASK[i]):
  - next state is BLOCK;
  - no bus activity.
- Winner i is not blocked:
  - i, `we`, `addr` and `wdata` are latched;
  - next state is SETUP.
- No request: next state is IDLE.
- SETUP, 1 cycle:
  - `vram_na` = ~latched address; `vram_nmcs` = 0;
  - `vram_nmoe` = `vram_nmwr` = 1;
  - `ack[i]` = 1.
- ACTIVE, STROBE cycles (down-counter):
  - read: `vram_nmoe` = 0;
  - write: `vram_nmwr` = 0, `vram_md_oe` = 1, `vram_md_out` = latched data.
- HOLD, 1 cycle:
  - strobes high, `vram_nmcs` stays 0;
  - write data still driven, `vram_md_oe` = 1;
  - read: `rdata` = the value captured on the last ACTIVE edge, `rvalid[i]` = 1;
  - write: no `rvalid`.
- BLOCK, 1 cycle:
  - `ack[i]` = 1;
  - read: `rvalid[i]` = 1 and `rdata` = all ones in the same cycle;
  - write: discarded;
  - then arbitrate again.
- `rdata` keeps its last value outside `rvalid` cycles.
- `lock` changing mid-access does not affect the access in progress.
- Requester rule: hold `req`/`we`/`addr`/`wdata` stable until `ack` is seen. `req` still high after `ack` counts as a new request.
- Simultaneous requests: lower-index channel wins; losers wait with no starvation guard (intended).
- `req` for a channel ≥NCH does not exist. With NCH=1 the arbiter degenerates to a sequencer.

## Timing
- Unblocked access occupies the bus for STROBE+2 cycles.
- Back-to-back: HOLD goes straight to SETUP, so throughput is one access per STROBE+2 cycles.
- Read latency: `req` at edge n → `ack` in cycle n+1 → `rvalid` in cycle n+2+STROBE.
- Blocked access: `ack`/`rvalid` in cycle n+1.
- Reset, asserted at any time, takes effect immediately:
  - state → IDLE;
  - `ack`, `rvalid`, `vram_md_oe` = 0;
  - `rdata` = 0, `vram_md_out` = 0;
  - `vram_na` = all ones;
  - `vram_nmcs`, `vram_nmoe`, `vram_nmwr` = 1.
- An access interrupted by reset is lost: no `ack`/`rvalid`, no bus write completes.

## Test plan
- Channel 1 reads 0x1A5, STROBE=1, `lock`=0, memory model returns 0x3C:
  - `ack[1]` at cycle +1;
  - `vram_na` = ~0x1A5;
  - `vram_nmoe` low for 1 cycle;
  - `rvalid[1]` at cycle +3 with `rdata` = 0x3C.
- Channel 2 writes 0x55 to 0x1FFF, STROBE=3:
  - `vram_nmwr` low for exactly 3 cycles;
  - `vram_md_oe` high from ACTIVE through HOLD;
  - model holds 0x55;
  - no `rvalid`.
- Channels 0, 1 and 2 request in the same cycle:
  - grants in order 0, 1, 2;
  - accesses back-to-back every STROBE+2 cycles, with no IDLE between them.
- `lock`=1 with default LOCK_MASK:
  - channel 1 read returns 0xFF with `ack`/`rvalid` in the same cycle and no `vram_nmcs` activity;
  - channel 1 write leaves the model unchanged;
  - channel 0 read proceeds normally.
- `lock` rises during channel 1's ACTIVE cycle: that access completes with real data, and the next channel 1 request is blocked.
- Reset asserted mid-ACTIVE of a write:
  - strobes, `vram_nmcs` and `vram_md_oe` go inactive asynchronously (before the next clock edge);
  - all outputs show their reset values;
  - after release, a new read completes normally.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Requester handshake and external VRAM bus shared by vram_arbiter and its users.
// The slave side is the arbiter; the master side is the requesters plus the VRAM pads.
interface vram_arbiter_if #(
    parameter int AW  = 13,
    parameter int DW  = 8,
    parameter int NCH = 3
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic              lock;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     vram_na;
    logic              vram_nmcs;
    logic              vram_nmoe;
    logic              vram_nmwr;
    logic [DW-1:0]     vram_md_out;
    logic              vram_md_oe;
    logic [DW-1:0]     vram_md_in;

    modport master (
        output req, we, addr, wdata, lock, vram_md_in,
        input  ack, rvalid, rdata, vram_na, vram_nmcs, vram_nmoe, vram_nmwr,
               vram_md_out, vram_md_oe
    );

    modport slave (
        input  req, we, addr, wdata, lock, vram_md_in,
        output ack, rvalid, rdata, vram_na, vram_nmcs, vram_nmoe, vram_nmwr,
               vram_md_out, vram_md_oe
    );
endinterface

// File: rtl/vram_arbiter.sv
// Fixed-priority VRAM arbiter and SRAM-style bus sequencer with PPU-mode-3 blocking.
// Channel 0 has the highest priority; locked channels read all-ones and drop writes.
module vram_arbiter #(
    parameter int             AW        = 13,
    parameter int             DW        = 8,
    parameter int             NCH       = 3,
    parameter int             STROBE    = 1,
    parameter logic [NCH-1:0] LOCK_MASK = NCH'(3'b110)
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = (STROBE > 1) ? $clog2(STROBE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD,
        S_BLOCK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW-1:0]   rdata_q;

    logic            win_valid;
    logic [CW-1:0]   win_ch;
    logic            win_blocked;
    logic            arbitrate;

    logic [NCH-1:0]  ack;
    logic [NCH-1:0]  rvalid;
    logic [AW-1:0]   na;
    logic            nmcs;
    logic            nmoe;
    logic            nmwr;
    logic            md_oe;

    // Lowest-index requester wins; scanning downwards leaves it as the final assignment.
    always_comb begin
        win_valid = 1'b0;
        win_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_valid = 1'b1;
                win_ch    = CW'(i);
            end
        end
    end

    assign win_blocked = bus.lock && LOCK_MASK[win_ch];

    always_comb begin
        state_d   = state_q;
        arbitrate = 1'b0;
        unique case (state_q)
            S_IDLE:   arbitrate = 1'b1;
            S_SETUP:  state_d = S_ACTIVE;
            S_ACTIVE: if (cnt_q == '0) state_d = S_HOLD;
            S_HOLD:   arbitrate = 1'b1;
            S_BLOCK:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (arbitrate) begin
            if (!win_valid) begin
                state_d = S_IDLE;
            end else if (win_blocked) begin
                state_d = S_BLOCK;
            end else begin
                state_d = S_SETUP;
            end
        end
    end

    // Bus and handshake outputs depend on state only, so reset clears them immediately.
    always_comb begin
        ack    = '0;
        rvalid = '0;
        na     = '1;
        nmcs   = 1'b1;
        nmoe   = 1'b1;
        nmwr   = 1'b1;
        md_oe  = 1'b0;
        unique case (state_q)
            S_SETUP: begin
                ack[ch_q] = 1'b1;
                na        = ~addr_q;
                nmcs      = 1'b0;
            end
            S_ACTIVE: begin
                na   = ~addr_q;
                nmcs = 1'b0;
                if (we_q) begin
                    nmwr  = 1'b0;
                    md_oe = 1'b1;
                end else begin
                    nmoe = 1'b0;
                end
            end
            S_HOLD: begin
                na   = ~addr_q;
                nmcs = 1'b0;
                if (we_q) begin
                    md_oe = 1'b1;
                end else begin
                    rvalid[ch_q] = 1'b1;
                end
            end
            S_BLOCK: begin
                ack[ch_q] = 1'b1;
                if (!we_q) rvalid[ch_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ack         = ack;
    assign bus.rvalid      = rvalid;
    assign bus.rdata       = rdata_q;
    assign bus.vram_na     = na;
    assign bus.vram_nmcs   = nmcs;
    assign bus.vram_nmoe   = nmoe;
    assign bus.vram_nmwr   = nmwr;
    assign bus.vram_md_oe  = md_oe;
    assign bus.vram_md_out = md_oe ? wdata_q : '0;

    // A blocked read loads all-ones at arbitration so rdata is ready in the BLOCK cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (arbitrate && win_valid) begin
                ch_q    <= win_ch;
                we_q    <= bus.we[win_ch];
                addr_q  <= bus.addr[int'(win_ch) * AW +: AW];
                wdata_q <= bus.wdata[int'(win_ch) * DW +: DW];
                if (win_blocked && !bus.we[win_ch]) rdata_q <= '1;
            end
            if (state_q == S_SETUP) begin
                cnt_q <= CNTW'(STROBE - 1);
            end else if (state_q == S_ACTIVE && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == S_ACTIVE && cnt_q == '0 && !we_q) rdata_q <= bus.vram_md_in;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a transaction-timeline model checks every cycle of a
// STROBE=3 instance, and a STROBE=1 instance covers the single-strobe read latency.
module tb_vram_arbiter;
    localparam int             AW      = 13;
    localparam int             DW      = 8;
    localparam int             NCH     = 3;
    localparam int             S       = 3;
    localparam logic [NCH-1:0] MASK    = 3'b110;
    localparam int             MEMSZ   = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_arbiter_if #(.AW(AW), .DW(DW), .NCH(NCH)) bif  ();
    vram_arbiter_if #(.AW(AW), .DW(DW), .NCH(NCH)) bif1 ();

    vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH), .STROBE(S), .LOCK_MASK(MASK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH), .STROBE(1), .LOCK_MASK(MASK)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif1.slave)
    );

    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a) ^ 8'h99;
    endfunction

    // External SRAMs: write on each clock edge that sees a selected, strobed write.
    logic [DW-1:0] mem  [0:MEMSZ-1];
    logic [DW-1:0] mem1 [0:MEMSZ-1];
    bit            mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEMSZ; i++) begin
                mem[i]  = init_val(i);
                mem1[i] = init_val(i);
            end
            mem_ready = 1'b1;
        end else begin
            if (!bif.vram_nmcs && !bif.vram_nmwr) mem[~bif.vram_na] = bif.vram_md_out;
            if (!bif1.vram_nmcs && !bif1.vram_nmwr) mem1[~bif1.vram_na] = bif1.vram_md_out;
        end
    end

    assign bif.vram_md_in  = mem[~bif.vram_na];
    assign bif1.vram_md_in = mem1[~bif1.vram_na];

    typedef struct {
        logic [NCH-1:0] ack;
        logic [NCH-1:0] rvalid;
        logic [AW-1:0]  na;
        logic           nmcs;
        logic           nmoe;
        logic           nmwr;
        logic           md_oe;
        logic [DW-1:0]  md_out;
        bit             rd_set;
        logic [DW-1:0]  rd_val;
    } exp_t;

    function automatic exp_t idle_exp();
        exp_t e;
        e.ack    = '0;
        e.rvalid = '0;
        e.na     = '1;
        e.nmcs   = 1'b1;
        e.nmoe   = 1'b1;
        e.nmwr   = 1'b1;
        e.md_oe  = 1'b0;
        e.md_out = '0;
        e.rd_set = 1'b0;
        e.rd_val = '0;
        return e;
    endfunction

    exp_t          expv [64];
    logic [DW-1:0] shadow [0:MEMSZ-1];
    bit            shadow_ready = 1'b0;
    int            cyc = 0;
    int            remaining = 0;
    bit            wr_pend = 1'b0;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    int            wr_at;

    // Model: on each free edge pick the winner and lay out the whole access as a timeline.
    always @(posedge clk) begin
        int            w;
        bit            found;
        bit            is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        cyc = cyc + 1;
        expv[(cyc + 63) % 64] = idle_exp();
        if (!shadow_ready) begin
            for (int i = 0; i < MEMSZ; i++) shadow[i] = init_val(i);
            shadow_ready = 1'b1;
        end
        if (reset) begin
            for (int k = 0; k < 64; k++) expv[k] = idle_exp();
            remaining = 0;
            wr_pend   = 1'b0;
        end else begin
            if (wr_pend && cyc == wr_at) begin
                shadow[wr_a] = wr_d;
                wr_pend      = 1'b0;
            end
            if (remaining > 0) begin
                remaining = remaining - 1;
            end else begin
                found = 1'b0;
                w     = 0;
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (bif.req[i]) begin
                        found = 1'b1;
                        w     = i;
                    end
                end
                if (found) begin
                    a     = bif.addr[w*AW +: AW];
                    d     = bif.wdata[w*DW +: DW];
                    is_wr = bif.we[w];
                    expv[cyc % 64].ack[w] = 1'b1;
                    if (bif.lock && MASK[w]) begin
                        if (!is_wr) begin
                            expv[cyc % 64].rvalid[w] = 1'b1;
                            expv[cyc % 64].rd_set    = 1'b1;
                            expv[cyc % 64].rd_val    = 8'hFF;
                        end
                        remaining = 1;
                    end else begin
                        for (int k = 0; k <= S + 1; k++) begin
                            expv[(cyc + k) % 64].na   = ~a;
                            expv[(cyc + k) % 64].nmcs = 1'b0;
                        end
                        for (int k = 1; k <= S; k++) begin
                            if (is_wr) begin
                                expv[(cyc + k) % 64].nmwr   = 1'b0;
                                expv[(cyc + k) % 64].md_oe  = 1'b1;
                                expv[(cyc + k) % 64].md_out = d;
                            end else begin
                                expv[(cyc + k) % 64].nmoe = 1'b0;
                            end
                        end
                        if (is_wr) begin
                            expv[(cyc + S + 1) % 64].md_oe  = 1'b1;
                            expv[(cyc + S + 1) % 64].md_out = d;
                            wr_pend = 1'b1;
                            wr_a    = a;
                            wr_d    = d;
                            wr_at   = cyc + S + 1;
                        end else begin
                            expv[(cyc + S + 1) % 64].rvalid[w] = 1'b1;
                            expv[(cyc + S + 1) % 64].rd_set    = 1'b1;
                            expv[(cyc + S + 1) % 64].rd_val    = shadow[a];
                        end
                        remaining = S + 1;
                    end
                end
            end
        end
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] cur_rdata = '0;

    int            ack_ch [$];
    int            ack_t  [$];
    int            rv_ch  [$];
    int            rv_t   [$];
    logic [DW-1:0] rv_data[$];
    int            n_wr_low, n_oe_high, n_cs_low;

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int onehot_idx(logic [NCH-1:0] v);
        int r = -1;
        for (int i = 0; i < NCH; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [38:0] out_bundle();
        return {bif.ack, bif.rvalid, bif.rdata, bif.vram_na, bif.vram_nmcs, bif.vram_nmoe,
                bif.vram_nmwr, bif.vram_md_oe, bif.vram_md_out};
    endfunction

    task automatic clear_rec();
        ack_ch.delete();
        ack_t.delete();
        rv_ch.delete();
        rv_t.delete();
        rv_data.delete();
        n_wr_low  = 0;
        n_oe_high = 0;
        n_cs_low  = 0;
    endtask

    // One cycle: compare against the model, log events, then let requesters drop acked reqs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            checkOutput("reset_outputs", 64'(out_bundle()),
                        64'({6'b0, 8'h00, 13'h1FFF, 4'b1110, 8'h00}));
            cur_rdata = '0;
        end else begin
            e = expv[cyc % 64];
            checkOutput("handshake", 64'({bif.ack, bif.rvalid}), 64'({e.ack, e.rvalid}));
            checkOutput("bus", 64'({bif.vram_na, bif.vram_nmcs, bif.vram_nmoe, bif.vram_nmwr, bif.vram_md_oe}),
                        64'({e.na, e.nmcs, e.nmoe, e.nmwr, e.md_oe}));
            if (e.md_oe) checkOutput("md_out", 64'(bif.vram_md_out), 64'(e.md_out));
            if (e.rd_set) cur_rdata = e.rd_val;
            checkOutput("rdata", 64'(bif.rdata), 64'(cur_rdata));
            if (|bif.ack) begin
                ack_ch.push_back(onehot_idx(bif.ack));
                ack_t.push_back(cyc);
            end
            if (|bif.rvalid) begin
                rv_ch.push_back(onehot_idx(bif.rvalid));
                rv_t.push_back(cyc);
                rv_data.push_back(bif.rdata);
            end
            if (!bif.vram_nmwr) n_wr_low++;
            if (bif.vram_md_oe) n_oe_high++;
            if (!bif.vram_nmcs) n_cs_low++;
        end
        for (int i = 0; i < NCH; i++) begin
            if (bif.ack[i])  bif.req[i]  = 1'b0;
            if (bif1.ack[i]) bif1.req[i] = 1'b0;
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(int ch, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        bif.we[ch]            = wr;
        bif.addr[ch*AW +: AW]  = a;
        bif.wdata[ch*DW +: DW] = d;
        bif.req[ch]           = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        bif.req     = '0;
        bif.we      = '0;
        bif.addr    = '0;
        bif.wdata   = '0;
        bif.lock    = 1'b0;
        bif1.req    = '0;
        bif1.we     = '0;
        bif1.addr   = '0;
        bif1.wdata  = '0;
        bif1.lock   = 1'b0;
        clear_rec();
        run(2);
        checkOutput("reset_na", 64'(bif.vram_na), 64'h1FFF);
        checkOutput("reset_strobes", 64'({bif.vram_nmcs, bif.vram_nmoe, bif.vram_nmwr}), 64'b111);
        reset = 1'b0;
        run(2);

        // Single-strobe read on channel 1 of the STROBE=1 instance.
        bif1.we[1]        = 1'b0;
        bif1.addr[AW +: AW] = 13'h01A5;
        bif1.req[1]       = 1'b1;
        tick();
        checkOutput("s1_ack", 64'(bif1.ack), 64'b010);
        checkOutput("s1_na", 64'(bif1.vram_na), 64'h1E5A);
        checkOutput("s1_nmoe_setup", 64'(bif1.vram_nmoe), 64'd1);
        tick();
        checkOutput("s1_nmoe_active", 64'(bif1.vram_nmoe), 64'd0);
        tick();
        checkOutput("s1_rvalid", 64'(bif1.rvalid), 64'b010);
        checkOutput("s1_rdata", 64'(bif1.rdata), 64'h3C);
        checkOutput("s1_nmoe_hold", 64'(bif1.vram_nmoe), 64'd1);
        tick();
        checkOutput("s1_rvalid_pulse", 64'(bif1.rvalid), 64'b000);

        // Channel 2 writes 0x55 to the top address.
        clear_rec();
        applyStimulus(2, 1'b1, 13'h1FFF, 8'h55);
        run(8);
        checkOutput("wr_ack_ch", 64'((ack_ch.size() > 0) ? ack_ch[0] : -1), 64'd2);
        checkOutput("wr_nmwr_cycles", 64'(n_wr_low), 64'd3);
        checkOutput("wr_md_oe_cycles", 64'(n_oe_high), 64'd4);
        checkOutput("wr_no_rvalid", 64'(rv_ch.size()), 64'd0);
        checkOutput("wr_mem", 64'(mem[13'h1FFF]), 64'h55);

        // Three simultaneous requests serialise by priority with no gap.
        clear_rec();
        applyStimulus(0, 1'b0, 13'h0010, 8'h00);
        applyStimulus(1, 1'b0, 13'h0020, 8'h00);
        applyStimulus(2, 1'b1, 13'h0030, 8'h77);
        run(20);
        checkOutput("pri_count", 64'(ack_ch.size()), 64'd3);
        checkOutput("pri_order", 64'({(ack_ch.size() > 2) ? ack_ch[0] : -1,
                                      (ack_ch.size() > 2) ? ack_ch[1] : -1,
                                      (ack_ch.size() > 2) ? ack_ch[2] : -1}),
                    64'({32'd0, 32'd1, 32'd2}));
        checkOutput("pri_spacing", 64'({(ack_t.size() > 2) ? ack_t[1] - ack_t[0] : -1,
                                        (ack_t.size() > 2) ? ack_t[2] - ack_t[1] : -1}),
                    64'({32'd5, 32'd5}));
        checkOutput("pri_busy", 64'(n_cs_low), 64'd15);
        checkOutput("pri_rdata0", 64'((rv_data.size() > 1) ? rv_data[0] : 8'h00), 64'h89);
        checkOutput("pri_rdata1", 64'((rv_data.size() > 1) ? rv_data[1] : 8'h00), 64'hB9);
        checkOutput("pri_mem", 64'(mem[13'h0030]), 64'h77);

        // Lock blocks channel 1 but not channel 0.
        bif.lock = 1'b1;
        clear_rec();
        applyStimulus(1, 1'b0, 13'h0042, 8'h00);
        run(4);
        checkOutput("blk_rd_data", 64'((rv_data.size() > 0) ? rv_data[0] : 8'h00), 64'hFF);
        checkOutput("blk_rd_same_cycle", 64'((rv_t.size() > 0 && ack_t.size() > 0) ? rv_t[0] - ack_t[0] : -1), 64'd0);
        applyStimulus(1, 1'b1, 13'h0042, 8'h12);
        run(4);
        checkOutput("blk_no_cs", 64'(n_cs_low), 64'd0);
        checkOutput("blk_wr_mem", 64'(mem[13'h0042]), 64'hDB);
        clear_rec();
        applyStimulus(0, 1'b0, 13'h0042, 8'h00);
        run(7);
        checkOutput("lock_ch0_rdata", 64'((rv_data.size() > 0) ? rv_data[0] : 8'h00), 64'hDB);
        checkOutput("lock_ch0_cs", 64'(n_cs_low), 64'd5);
        bif.lock = 1'b0;

        // Lock rising mid-access only affects the next arbitration.
        clear_rec();
        applyStimulus(1, 1'b0, 13'h00AB, 8'h00);
        run(2);
        bif.lock = 1'b1;
        run(6);
        checkOutput("midlock_rdata", 64'((rv_data.size() > 0) ? rv_data[0] : 8'h00), 64'h32);
        clear_rec();
        applyStimulus(1, 1'b0, 13'h00AB, 8'h00);
        run(3);
        checkOutput("midlock_next_blocked", 64'((rv_data.size() > 0) ? rv_data[0] : 8'h00), 64'hFF);
        checkOutput("midlock_next_no_cs", 64'(n_cs_low), 64'd0);
        bif.lock = 1'b0;

        // Reset in the first ACTIVE cycle of a write.
        clear_rec();
        applyStimulus(0, 1'b1, 13'h0123, 8'hA7);
        run(2);
        checkOutput("rst_pre_nmwr", 64'(bif.vram_nmwr), 64'd0);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_async_strobes", 64'({bif.vram_nmcs, bif.vram_nmoe, bif.vram_nmwr, bif.vram_md_oe}), 64'b1110);
        checkOutput("rst_async_all", 64'(out_bundle()), 64'({6'b0, 8'h00, 13'h1FFF, 4'b1110, 8'h00}));
        run(2);
        reset = 1'b0;
        run(1);
        checkOutput("rst_mem_untouched", 64'(mem[13'h0123]), 64'hBA);
        clear_rec();
        applyStimulus(0, 1'b0, 13'h1FFF, 8'h00);
        run(7);
        checkOutput("rst_after_count", 64'(rv_ch.size()), 64'd1);
        checkOutput("rst_after_rdata", 64'((rv_data.size() > 0) ? rv_data[0] : 8'h00), 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
